// File: rtl/uart_frame_tx.sv
// 8N1 UART transmitter for short packed-ASCII messages (up to MAX_CHARS characters).
// The first character goes out first, and busy/done status is reported back to the requester.
module uart_frame_tx #(
    parameter int CLK_PER_BIT = 703,
    parameter int STOP_BITS   = 1,
    parameter int MAX_CHARS   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_uart,
    input  logic [79:0] read_data,
    input  logic [5:0]  nummax,
    output logic        txd,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [3:0]  char_idx
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BIT_LAST = 16'(CLK_PER_BIT - 1);

    state_t      state, state_nxt;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic        stop_cnt;
    logic [3:0]  len;
    logic [79:0] msg;
    logic [6:0]  sh;
    logic [3:0]  len_c, pad;
    logic [79:0] msg_aligned;
    logic        accept, bit_end, stop_last, char_last;
    logic        txd_d, busy_d, done_d;

    always_comb begin
        len_c = nummax[3:0];
        if (nummax > 6'(MAX_CHARS))
            len_c = 4'(MAX_CHARS);
    end

    // Left-align the message so the current character is always the top byte of msg.
    assign pad         = 4'd10 - len_c;
    assign msg_aligned = read_data << {pad, 3'b000};

    assign accept    = (state == IDLE) && en_uart && (nummax != 6'd0) && !tx_done;
    assign bit_end   = (baud_cnt == BIT_LAST);
    assign stop_last = (STOP_BITS == 1) || stop_cnt;
    assign char_last = (char_idx == len - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = START;
            START: if (bit_end) state_nxt = DATA;
            DATA:  if (bit_end && bit_cnt == 3'd7) state_nxt = STOP;
            STOP:  if (bit_end && stop_last) state_nxt = char_last ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; txd only moves on bit boundaries.
    always_comb begin
        txd_d  = txd;
        busy_d = (state_nxt != IDLE);
        done_d = (state == STOP) && (state_nxt == IDLE);
        case (state)
            IDLE:  if (accept) txd_d = 1'b0;
            START: if (bit_end) txd_d = msg[72];
            DATA:  if (bit_end) txd_d = (bit_cnt == 3'd7) ? 1'b1 : sh[0];
            STOP:  if (bit_end && stop_last) txd_d = char_last;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            txd     <= txd_d;
            tx_busy <= busy_d;
            tx_done <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            len      <= '0;
            msg      <= '0;
            sh       <= '0;
            char_idx <= '0;
        end else if (accept) begin
            msg      <= msg_aligned;
            len      <= len_c;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            char_idx <= '0;
        end else if (state != IDLE) begin
            if (bit_end) begin
                baud_cnt <= '0;
                case (state)
                    START: sh <= msg[79:73];
                    DATA: begin
                        sh      <= {1'b0, sh[6:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    STOP: begin
                        if (stop_last) begin
                            stop_cnt <= 1'b0;
                            if (char_last) begin
                                char_idx <= '0;
                            end else begin
                                char_idx <= char_idx + 4'd1;
                                msg      <= msg << 8;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: two instances (1 and 2 stop bits) at 4 clocks per bit.
// Frames are decoded mid-bit and compared against hand-written expected bytes and timings.
module tb_uart_frame_tx;

    localparam logic [79:0] TEN = 80'h2A41_3038_2D32_5F56_3423;  // "*A08-2_V4#"

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        en1 = 1'b0, en2 = 1'b0;
    logic [79:0] rd1 = '0, rd2 = '0;
    logic [5:0]  nm1 = '0, nm2 = '0;
    logic        txd1, busy1, done1, txd2, busy2, done2;
    logic [3:0]  ci1, ci2;
    int          checks = 0, passes = 0, fails = 0;

    uart_frame_tx #(.CLK_PER_BIT(4), .STOP_BITS(1), .MAX_CHARS(10)) dut1 (
        .clk(clk), .rst_n(rst_n), .en_uart(en1), .read_data(rd1), .nummax(nm1),
        .txd(txd1), .tx_busy(busy1), .tx_done(done1), .char_idx(ci1));

    uart_frame_tx #(.CLK_PER_BIT(4), .STOP_BITS(2), .MAX_CHARS(10)) dut2 (
        .clk(clk), .rst_n(rst_n), .en_uart(en2), .read_data(rd2), .nummax(nm2),
        .txd(txd2), .tx_busy(busy2), .tx_done(done2), .char_idx(ci2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic e, input logic [79:0] d, input logic [5:0] n);
        if (sel == 0) begin en1 = e; rd1 = d; nm1 = n; end
        else          begin en2 = e; rd2 = d; nm2 = n; end
    endtask

    task automatic sample(input int sel, output logic t, output logic b, output logic dn,
                          output logic [3:0] ci);
        if (sel == 0) begin t = txd1; b = busy1; dn = done1; ci = ci1; end
        else          begin t = txd2; b = busy2; dn = done2; ci = ci2; end
    endtask

    // Called at a negedge; request is sampled at the next posedge (cycle 0).
    // inj_a/inj_b: cycles in which a conflicting request is presented.
    task automatic run_msg(input int sel, input logic [79:0] data, input logic [5:0] n,
                           input int exp_len, input int sb, input logic [0:9][7:0] expb,
                           input int inj_a, input int inj_b);
        int f, total, busy_cnt, done_cnt, done_at, pos, k, bi;
        logic [7:0] rx;
        logic fok, t, b, dn;
        logic [3:0] ci;
        f = (9 + sb) * 4;
        total = exp_len * f;
        busy_cnt = 0; done_cnt = 0; done_at = -1; rx = '0; fok = 1'b0;
        drive(sel, 1'b1, data, n);
        @(negedge clk);
        for (int c = 1; c <= total + 1; c++) begin
            if (c == inj_a || c == inj_b) drive(sel, 1'b1, ~data, 6'd3);
            else                          drive(sel, 1'b0, ~data, 6'd7);
            sample(sel, t, b, dn, ci);
            if (b) busy_cnt++;
            if (dn) begin done_cnt++; done_at = c; end
            if (c == 1) chk("first_start_low", {31'd0, t}, 32'd0);
            if (c == total + 1) chk("idle_txd_at_done", {31'd0, t}, 32'd1);
            if (c <= total) begin
                pos = (c - 1) % f;
                k   = (c - 1) / f;
                bi  = pos / 4;
                if (pos % 4 == 2) begin
                    if (bi == 0) begin
                        fok = (t == 1'b0);
                        rx  = '0;
                        chk("char_idx", {28'd0, ci}, k);
                    end else if (bi <= 8) begin
                        rx[bi-1] = t;
                    end else begin
                        fok = fok & t;
                    end
                end
                if (pos == f - 1) begin
                    chk("frame_start_stop", {31'd0, fok}, 32'd1);
                    chk("char_byte", {24'd0, rx}, {24'd0, expb[k]});
                end
            end
            @(negedge clk);
        end
        drive(sel, 1'b0, ~data, 6'd7);
        chk("busy_cycles", busy_cnt, total);
        chk("done_pulses", done_cnt, 1);
        chk("done_cycle", done_at, total + 1);
    endtask

    initial begin
        int act;
        repeat (3) @(negedge clk);
        chk("rst_txd1",  {31'd0, txd1},  32'd1);
        chk("rst_busy1", {31'd0, busy1}, 32'd0);
        chk("rst_done1", {31'd0, done1}, 32'd0);
        chk("rst_ci1",   {28'd0, ci1},   32'd0);
        chk("rst_txd2",  {31'd0, txd2},  32'd1);
        chk("rst_busy2", {31'd0, busy2}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three characters, junk above the used bytes
        run_msg(0, {56'hDEAD_BEEF_0BAD_F0, 24'h2A3123}, 6'd3, 3, 1,
                {8'h2A, 8'h31, 8'h23, 56'h0}, -1, -1);
        // Ten characters
        run_msg(0, TEN, 6'd10, 10, 1, TEN, -1, -1);

        // Zero count: no activity
        drive(0, 1'b1, TEN, 6'd0);
        @(negedge clk);
        drive(0, 1'b0, TEN, 6'd0);
        act = 0;
        repeat (20) begin
            if (!txd1 || busy1 || done1) act++;
            @(negedge clk);
        end
        chk("zero_count_idle", act, 0);

        // Overflow count clamps to ten
        run_msg(0, TEN, 6'd15, 10, 1, TEN, -1, -1);

        // Collisions during character 1 and on the done cycle, then back-to-back request
        run_msg(0, {56'h0, 24'h2A3123}, 6'd3, 3, 1, {8'h2A, 8'h31, 8'h23, 56'h0}, 50, 121);
        run_msg(0, {56'h0, 24'h2A3023}, 6'd3, 3, 1, {8'h2A, 8'h30, 8'h23, 56'h0}, -1, -1);

        // Two stop bits
        run_msg(1, {56'h0, 24'h2A3023}, 6'd3, 3, 2, {8'h2A, 8'h30, 8'h23, 56'h0}, -1, -1);

        // Reset mid-message
        drive(0, 1'b1, TEN, 6'd10);
        @(negedge clk);
        drive(0, 1'b0, TEN, 6'd10);
        repeat (15) @(negedge clk);
        chk("pre_reset_busy", {31'd0, busy1}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_txd",  {31'd0, txd1},  32'd1);
        chk("async_rst_busy", {31'd0, busy1}, 32'd0);
        chk("async_rst_done", {31'd0, done1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        repeat (30) begin
            if (!txd1 || busy1 || done1) act++;
            @(negedge clk);
        end
        chk("post_reset_idle", act, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
